// File: rtl/result_reader.sv
// result_reader: after an ALU-done pulse, reads NUM_WORDS result words from
// SRAM addresses 0..NUM_WORDS-1, presents each on a valid/ready stream and
// tracks the largest word of the run and the address it came from.
module result_reader #(
    parameter int NUM_WORDS = 32,
    parameter int DATA_W    = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              ram_cs_n,
    output logic              ram_we_n,
    output logic [7:0]        ram_addr,
    input  logic [31:0]       ram_rdata,
    input  logic              ram_ry,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] max_val,
    output logic [7:0]        max_addr,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_CAPTURE = 3'd2,
        S_OUTPUT  = 3'd3,
        S_FINISH  = 3'd4
    } state_t;

    localparam logic [7:0] LAST_ADDR = 8'(NUM_WORDS - 1);

    state_t              r_state;
    state_t              w_next;
    logic [7:0]          r_cnt;
    logic [DATA_W-1:0]   r_out_data;
    logic [DATA_W-1:0]   r_max_val;
    logic [7:0]          r_max_addr;
    logic [DATA_W-1:0]   w_word;
    logic                w_last;
    logic                w_cs_n;
    logic                w_valid;
    logic                w_busy;
    logic                w_done;

    // Only the low DATA_W bits of a read carry the result.
    assign w_word = ram_rdata[DATA_W-1:0];
    assign w_last = (r_cnt == LAST_ADDR);

    generate
        if (DATA_W < 32) begin : g_upper
            // Upper read-data bits are deliberately discarded.
            logic w_unused_upper;
            assign w_unused_upper = ^ram_rdata[31:DATA_W];
        end
    endgenerate

    // State register; reset forces IDLE immediately, aborting any run.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and state-decoded control outputs.
    always_comb begin
        w_next  = r_state;
        w_cs_n  = 1'b1;
        w_valid = 1'b0;
        w_busy  = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_ISSUE;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_ISSUE: begin
                w_busy = 1'b1;
                if (ram_ry) begin
                    w_cs_n = 1'b0;
                    w_next = S_CAPTURE;
                end else begin
                    w_next = S_ISSUE;
                end
            end
            S_CAPTURE: begin
                w_busy = 1'b1;
                w_next = S_OUTPUT;
            end
            S_OUTPUT: begin
                w_busy  = 1'b1;
                w_valid = 1'b1;
                if (out_ready) begin
                    w_next = w_last ? S_FINISH : S_ISSUE;
                end else begin
                    w_next = S_OUTPUT;
                end
            end
            S_FINISH: begin
                // start here is ignored: a new run needs start seen in IDLE.
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Address counter, captured word and running maximum.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt      <= 8'd0;
            r_out_data <= '0;
            r_max_val  <= '0;
            r_max_addr <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cnt      <= 8'd0;
                        r_max_val  <= '0;
                        r_max_addr <= 8'd0;
                    end
                end
                S_CAPTURE: begin
                    r_out_data <= w_word;
                    // Strictly greater keeps the earliest address on ties.
                    if ((r_cnt == 8'd0) || (w_word > r_max_val)) begin
                        r_max_val  <= w_word;
                        r_max_addr <= r_cnt;
                    end
                end
                S_OUTPUT: begin
                    // Counter stops at the last address; it never wraps.
                    if (out_ready && !w_last) begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ram_cs_n  = w_cs_n;
    assign ram_we_n  = 1'b1;
    assign ram_addr  = r_cnt;
    assign out_data  = r_out_data;
    assign out_valid = w_valid;
    assign max_val   = r_max_val;
    assign max_addr  = r_max_addr;
    assign busy      = w_busy;
    assign done      = w_done;

endmodule

// File: tb/tb_result_reader.sv
// Directed bench for result_reader with NUM_WORDS=4, DATA_W=18 and a
// behavioural SRAM whose read data appears the cycle after the address.
module tb_result_reader;

    localparam int NW = 4;
    localparam int DW = 18;

    logic          clk;
    logic          rst;
    logic          start;
    logic          ram_cs_n;
    logic          ram_we_n;
    logic [7:0]    ram_addr;
    logic [31:0]   ram_rdata;
    logic          ram_ry;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] max_val;
    logic [7:0]    max_addr;
    logic          busy;
    logic          done;

    logic [31:0]   mem [256];

    int            n_checks;
    int            n_fails;
    int            cyc;
    int            start_cyc;
    int            done_cnt;
    logic [31:0]   got_data [$];
    int            got_cyc  [$];
    logic [31:0]   exp_q    [$];

    result_reader #(.NUM_WORDS(NW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ram_cs_n  (ram_cs_n),
        .ram_we_n  (ram_we_n),
        .ram_addr  (ram_addr),
        .ram_rdata (ram_rdata),
        .ram_ry    (ram_ry),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .max_val   (max_val),
        .max_addr  (max_addr),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: registered read, data valid the cycle after the address.
    always @(posedge clk) begin
        if (!ram_cs_n) ram_rdata <= mem[ram_addr];
    end

    // Monitor: cycle count, accepted words with their cycle, done pulses.
    always @(posedge clk) begin
        if (start) start_cyc = cyc;
        if (out_valid && out_ready) begin
            got_data.push_back(32'(out_data));
            got_cyc.push_back(cyc);
        end
        if (done) done_cnt = done_cnt + 1;
        cyc = cyc + 1;
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_fails = n_fails + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk_eq({tag, " cs_n"},  32'(ram_cs_n),  32'd1);
        chk_eq({tag, " we_n"},  32'(ram_we_n),  32'd1);
        chk_eq({tag, " addr"},  32'(ram_addr),  32'd0);
        chk_eq({tag, " data"},  32'(out_data),  32'd0);
        chk_eq({tag, " valid"}, 32'(out_valid), 32'd0);
        chk_eq({tag, " max"},   32'(max_val),   32'd0);
        chk_eq({tag, " maxa"},  32'(max_addr),  32'd0);
        chk_eq({tag, " busy"},  32'(busy),      32'd0);
        chk_eq({tag, " done"},  32'(done),      32'd0);
    endtask

    task automatic fill_times3();
        for (int i = 0; i < 256; i++) mem[i] = 32'(i * 3);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 200) begin
            @(negedge clk);
            n = n + 1;
        end
        chk_eq({tag, " done seen in time"}, 32'(done_cnt != d0), 32'd1);
        repeat (5) @(negedge clk);
        chk_eq({tag, " done count"}, 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic wait_words(input string tag, input int cnt);
        int n;
        n = 0;
        while (got_data.size() < cnt && n < 200) begin
            @(negedge clk);
            n = n + 1;
        end
        chk_eq({tag, " words in time"}, 32'(got_data.size() >= cnt), 32'd1);
    endtask

    task automatic check_words(input string tag);
        chk_eq({tag, " word count"}, 32'(got_data.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_data.size(); i++) begin
            chk_eq($sformatf("%s word%0d", tag, i), got_data[i], exp_q[i]);
        end
    endtask

    initial begin
        int d0;
        int n;
        n_checks  = 0;
        n_fails   = 0;
        cyc       = 0;
        start_cyc = 0;
        done_cnt  = 0;
        rst       = 1'b0;
        start     = 1'b0;
        ram_ry    = 1'b1;
        out_ready = 1'b1;
        fill_times3();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Basic run: words 0,3,6,9, one word every 3 cycles.
        got_data.delete(); got_cyc.delete();
        d0 = done_cnt;
        pulse_start();
        chk_eq("run1 busy in issue", 32'(busy), 32'd1);
        chk_eq("run1 cs_n in issue", 32'(ram_cs_n), 32'd0);
        chk_eq("run1 addr0", 32'(ram_addr), 32'd0);
        wait_done("run1", d0);
        exp_q = '{32'd0, 32'd3, 32'd6, 32'd9};
        check_words("run1");
        for (int i = 0; i < got_cyc.size(); i++) begin
            chk_eq($sformatf("run1 word%0d latency", i),
                   32'(got_cyc[i] - start_cyc), 32'(3 * (i + 1)));
        end
        chk_eq("run1 max_val", 32'(max_val), 32'd9);
        chk_eq("run1 max_addr", 32'(max_addr), 32'd3);
        chk_eq("run1 busy after", 32'(busy), 32'd0);
        chk_eq("run1 valid idle", 32'(out_valid), 32'd0);

        // Backpressure on word 1 for 5 cycles.
        got_data.delete(); got_cyc.delete();
        d0 = done_cnt;
        pulse_start();
        wait_words("bp", 1);
        out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n = n + 1;
        end
        for (int i = 0; i < 5; i++) begin
            chk_eq($sformatf("bp valid c%0d", i), 32'(out_valid), 32'd1);
            chk_eq($sformatf("bp data c%0d", i), 32'(out_data), 32'd3);
            chk_eq($sformatf("bp cs_n c%0d", i), 32'(ram_cs_n), 32'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        wait_done("bp", d0);
        check_words("bp");

        // SRAM not ready for 4 cycles in ISSUE.
        got_data.delete(); got_cyc.delete();
        d0 = done_cnt;
        ram_ry = 1'b0;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            chk_eq($sformatf("ry0 cs_n c%0d", i), 32'(ram_cs_n), 32'd1);
            @(negedge clk);
        end
        ram_ry = 1'b1;
        #1;
        chk_eq("ry1 cs_n issues", 32'(ram_cs_n), 32'd0);
        chk_eq("ry1 addr", 32'(ram_addr), 32'd0);
        wait_done("ry", d0);
        check_words("ry");

        // Upper bits dropped; tie keeps the earlier address.
        mem[0] = 32'hFFFC_0005;
        mem[1] = 32'hFFFF_FFFF;
        mem[2] = 32'hFFFF_FFFF;
        mem[3] = 32'hFFFC_0002;
        got_data.delete(); got_cyc.delete();
        d0 = done_cnt;
        pulse_start();
        wait_done("wide", d0);
        exp_q = '{32'h5, 32'h3FFFF, 32'h3FFFF, 32'h2};
        check_words("wide");
        chk_eq("wide max_val", 32'(max_val), 32'h3FFFF);
        chk_eq("wide max_addr", 32'(max_addr), 32'd1);

        // Reset while word 2 is presented.
        fill_times3();
        got_data.delete(); got_cyc.delete();
        pulse_start();
        wait_words("rstmid", 2);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n = n + 1;
        end
        chk_eq("rstmid word2 shown", 32'(out_data), 32'd6);
        d0 = done_cnt;
        rst = 1'b0;
        #1;
        check_reset_outputs("rstmid");
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        chk_eq("rstmid no done", 32'(done_cnt - d0), 32'd0);
        got_data.delete(); got_cyc.delete();
        exp_q = '{32'd0, 32'd3, 32'd6, 32'd9};
        pulse_start();
        chk_eq("rstmid restart addr", 32'(ram_addr), 32'd0);
        chk_eq("rstmid restart cs_n", 32'(ram_cs_n), 32'd0);
        wait_done("rstmid", d0);
        check_words("rstmid");

        // start mid-run and in the FINISH cycle are ignored.
        got_data.delete(); got_cyc.delete();
        d0 = done_cnt;
        pulse_start();
        wait_words("ign", 2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n = n + 1;
        end
        chk_eq("ign done reached", 32'(done), 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk_eq("ign done count", 32'(done_cnt - d0), 32'd1);
        check_words("ign");
        chk_eq("ign idle busy", 32'(busy), 32'd0);
        chk_eq("ign idle cs_n", 32'(ram_cs_n), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/result_reader.md
RESULT_READER -- requirements
Module: result_reader

Interface
REQ-001 Parameter NUM_WORDS, default 32: number of result words read per run, range 1..256.
REQ-002 Parameter DATA_W, default 18: width of one result word, taken from the SRAM read data bits [DATA_W-1:0].
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-low reset.
REQ-005 Port start, input, 1: one-cycle pulse (the ALU-done event) meaning results are in SRAM addresses 0..NUM_WORDS-1.
REQ-006 Port ram_cs_n, output, 1: SRAM chip select, active low.
REQ-007 Port ram_we_n, output, 1: SRAM write enable, active low; this block only reads.
REQ-008 Port ram_addr, output, 8: SRAM read address.
REQ-009 Port ram_rdata, input, 32: SRAM read data, valid on the cycle after the address is issued.
REQ-010 Port ram_ry, input, 1: SRAM ready; a read is issued only while it is 1.
REQ-011 Port out_data, output, DATA_W: current result word.
REQ-012 Port out_valid, output, 1: out_data is valid.
REQ-013 Port out_ready, input, 1: downstream accepts out_data.
REQ-014 Port max_val, output, DATA_W: largest word seen in the current or last run, unsigned.
REQ-015 Port max_addr, output, 8: address of max_val.
REQ-016 Port busy, output, 1: a run is in progress.
REQ-017 Port done, output, 1: one-cycle pulse at the end of a run.

Function
REQ-018 The FSM states SHALL be IDLE, ISSUE, CAPTURE, OUTPUT and FINISH.
REQ-019 IDLE to ISSUE on start=1; clear the address counter, max_val and max_addr to 0; busy=1 from the next cycle.
REQ-020 ISSUE: if ram_ry=1, drive ram_cs_n=0 and ram_addr=counter, then go to CAPTURE; if ram_ry=0, stay in ISSUE with ram_cs_n=1.
REQ-021 CAPTURE: register ram_rdata[DATA_W-1:0] into out_data, ignore bits 31:DATA_W, go to OUTPUT.
REQ-022 CAPTURE: if the captured word is strictly greater than max_val, or it is the first word of the run, update max_val and max_addr; ties keep the earlier address.
REQ-023 OUTPUT: hold out_valid=1 and keep out_data stable until out_ready=1.
REQ-024 OUTPUT: on the handshake cycle (out_valid and out_ready both 1), go to ISSUE with counter+1, or to FINISH if counter=NUM_WORDS-1.
REQ-025 Latency: first out_valid 3 cycles after start when ram_ry=1; with out_ready held at 1, one word every 3 cycles.
REQ-026 FINISH: pulse done=1 for one cycle, deassert busy, return to IDLE.
REQ-027 max_val and max_addr hold their value after the run until the next start.
REQ-028 start while busy=1 SHALL be ignored.
REQ-029 start in the same cycle as FINISH SHALL be ignored; a new run needs start while in IDLE.
REQ-030 ram_we_n SHALL be constant 1.
REQ-031 ram_cs_n SHALL be 1 in every state except an ISSUE cycle with ram_ry=1.
REQ-032 The address counter SHALL never exceed NUM_WORDS-1; ram_addr never wraps within a run.
REQ-033 out_valid SHALL never be 1 outside OUTPUT.

Reset
REQ-034 While rst=0, the block SHALL enter IDLE immediately, regardless of the clock.
REQ-035 Output reset values: ram_cs_n=1, ram_we_n=1, ram_addr=0, out_data=0, out_valid=0, max_val=0, max_addr=0, busy=0, done=0.
REQ-036 Reset mid-run SHALL abort the run with no done pulse; the next start begins at address 0.

Verification
REQ-037 SRAM holds mem[i]=i*3, NUM_WORDS=4, out_ready=1, ram_ry=1, start pulse -> words 0,3,6,9 each one cycle on out_valid, spaced 3 cycles apart; first word 3 cycles after start; done once; max_val=9, max_addr=3.
REQ-038 out_ready=0 for 5 cycles while word 1 is presented -> out_valid and out_data stay stable; no duplicated or dropped words; order unchanged.
REQ-039 ram_ry=0 for 4 cycles in ISSUE -> ram_cs_n=1 throughout; the read issues on the first cycle ram_ry=1; data is correct.
REQ-040 mem={5,0x3FFFF,0x3FFFF,2}, with bits 31:18 of each word set to 1 -> out_data has upper bits dropped; max_val=0x3FFFF, max_addr=1 (tie keeps first).
REQ-041 rst=0 while in OUTPUT of word 2 -> outputs at reset values immediately; no done; a new start reads from address 0.
REQ-042 start pulsed again mid-run, and in the FINISH cycle -> both ignored; exactly NUM_WORDS words and one done pulse.
